// File: rtl/c432_irq_pkg.sv
// Shared types and constants for the c432 interrupt dispatch stage.
// Bus codes mirror the encoder's request flags in priority order A > B > C.
package c432_irq_pkg;

   localparam int unsigned VEC_W = 6;

   localparam logic [1:0] BUS_NONE = 2'b00;
   localparam logic [1:0] BUS_A    = 2'b01;
   localparam logic [1:0] BUS_B    = 2'b10;
   localparam logic [1:0] BUS_C    = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      ACK_LOW,
      HOLD
   } state_e;

   function automatic logic [1:0] bus_encode(input logic pa, input logic pb, input logic pc);
      if (pa) begin
         return BUS_A;
      end else if (pb) begin
         return BUS_B;
      end else if (pc) begin
         return BUS_C;
      end
      return BUS_NONE;
   endfunction

endpackage

// File: rtl/c432_irq_filter.sv
// Input register, bus encoder and stability filter for the encoder outputs.
// stab_q counts how many consecutive cycles the registered candidate has held its value.
module c432_irq_filter
   import c432_irq_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             hold_i,
   input  logic             pa_i,
   input  logic             pb_i,
   input  logic             pc_i,
   input  logic [3:0]       chan_i,
   output logic [VEC_W-1:0] cand_o,
   output logic             cand_valid_o
);

   localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES);

   logic [6:0]       raw_d, raw_q;
   logic [3:0]       stab_d, stab_q;
   logic [VEC_W-1:0] cand_next, cand_cur;

   assign raw_d     = {pa_i, pb_i, pc_i, chan_i};
   assign cand_next = {bus_encode(raw_d[6], raw_d[5], raw_d[4]), raw_d[3:0]};
   assign cand_cur  = {bus_encode(raw_q[6], raw_q[5], raw_q[4]), raw_q[3:0]};

   always_comb begin
      stab_d = stab_q;
      if (hold_i) begin
         stab_d = 4'd0;
      end else if (cand_next != cand_cur) begin
         stab_d = 4'd1;
      end else if (stab_q < STAB_MAX) begin
         stab_d = stab_q + 4'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         raw_q  <= '0;
         stab_q <= '0;
      end else begin
         raw_q  <= raw_d;
         stab_q <= stab_d;
      end
   end

   assign cand_o       = cand_cur;
   assign cand_valid_o = (cand_cur[5:4] != BUS_NONE) && (stab_q == STAB_MAX);

endmodule

// File: rtl/c432_irq_dispatch.sv
// Dispatches deglitched gf_c432 encoder vectors to a CPU over a four-phase req/ack
// handshake, with ack timeout, post-service holdoff and a completed-service counter.
module c432_irq_dispatch
   import c432_irq_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 2,
   parameter int unsigned TIMEOUT       = 255,
   parameter int unsigned HOLDOFF       = 4,
   parameter int unsigned CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             G223gat,
   input  logic             G329gat,
   input  logic             G370gat,
   input  logic             G421gat,
   input  logic             G430gat,
   input  logic             G431gat,
   input  logic             G432gat,
   input  logic             irq_ack,
   output logic             irq_req,
   output logic [VEC_W-1:0] irq_vec,
   output logic             irq_timeout,
   output logic             busy,
   output logic [CNT_W-1:0] svc_count
);

   localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
   // HOLDOFF of 0 still spends one cycle in HOLD before returning to IDLE.
   localparam logic [7:0]  HOLD_LAST = 8'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);

   state_e           state_d, state_q;
   logic [15:0]      tmo_d, tmo_q;
   logic [7:0]       hold_d, hold_q;
   logic             req_d, req_q;
   logic [VEC_W-1:0] vec_d, vec_q;
   logic             pulse_d, pulse_q;
   logic [CNT_W-1:0] svc_d, svc_q;

   logic [VEC_W-1:0] cand;
   logic             cand_valid;

   c432_irq_filter #(
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_filter (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .hold_i       (state_q == HOLD),
      .pa_i         (G223gat),
      .pb_i         (G329gat),
      .pc_i         (G370gat),
      .chan_i       ({G421gat, G430gat, G431gat, G432gat}),
      .cand_o       (cand),
      .cand_valid_o (cand_valid)
   );

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      hold_d  = hold_q;
      req_d   = req_q;
      vec_d   = vec_q;
      pulse_d = 1'b0;
      svc_d   = svc_q;
      unique case (state_q)
         IDLE: begin
            if (en && cand_valid && !irq_ack) begin
               vec_d   = cand;
               req_d   = 1'b1;
               tmo_d   = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            // Ack takes priority over a timeout expiring in the same cycle.
            if (irq_ack) begin
               req_d   = 1'b0;
               svc_d   = svc_q + CNT_W'(1);
               state_d = ACK_LOW;
            end else if (tmo_q == TMO_LAST) begin
               req_d   = 1'b0;
               pulse_d = 1'b1;
               hold_d  = '0;
               state_d = HOLD;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         ACK_LOW: begin
            if (!irq_ack) begin
               hold_d  = '0;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (hold_q == HOLD_LAST) begin
               state_d = IDLE;
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tmo_q   <= '0;
         hold_q  <= '0;
         req_q   <= 1'b0;
         vec_q   <= '0;
         pulse_q <= 1'b0;
         svc_q   <= '0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         hold_q  <= hold_d;
         req_q   <= req_d;
         vec_q   <= vec_d;
         pulse_q <= pulse_d;
         svc_q   <= svc_d;
      end
   end

   assign irq_req     = req_q;
   assign irq_vec     = vec_q;
   assign irq_timeout = pulse_q;
   assign busy        = (state_q != IDLE);
   assign svc_count   = svc_q;

endmodule

// File: tb/tb_c432_irq_dispatch.sv
// Scoreboard bench for c432_irq_dispatch: expected vectors are queued by the stimulus
// and checked by a monitor on every rising edge of irq_req.
module tb_c432_irq_dispatch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en, pa, pb, pc, ack;
   logic [3:0]  chan;
   logic        irq_req, irq_timeout, busy;
   logic [5:0]  irq_vec;
   logic [15:0] svc_count;

   int errors = 0;
   int checks = 0;
   logic [5:0] exp_q[$];
   logic       prev_req = 1'b0;

   always #5 clk = ~clk;

   c432_irq_dispatch #(
      .STABLE_CYCLES (2),
      .TIMEOUT       (8),
      .HOLDOFF       (4),
      .CNT_W         (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .G223gat     (pa),
      .G329gat     (pb),
      .G370gat     (pc),
      .G421gat     (chan[3]),
      .G430gat     (chan[2]),
      .G431gat     (chan[1]),
      .G432gat     (chan[0]),
      .irq_ack     (ack),
      .irq_req     (irq_req),
      .irq_vec     (irq_vec),
      .irq_timeout (irq_timeout),
      .busy        (busy),
      .svc_count   (svc_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic a, input logic b, input logic c, input logic [3:0] ch);
      pa   = a;
      pb   = b;
      pc   = c;
      chan = ch;
   endtask

   // Waits on negedges for irq_req; n is the number of negedges waited.
   task automatic wait_req(input int bound, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!irq_req && n < bound);
      if (!irq_req) begin
         checks++;
         errors++;
         $display("FAIL wait_req: got no request expected request within %0d cycles", bound);
      end
   endtask

   // Monitor: each new request must match the oldest queued expectation.
   always @(negedge clk) begin
      if (irq_req && !prev_req) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got vec %0h expected no request", irq_vec);
         end else begin
            check("sb_vec", 32'(irq_vec), 32'(exp_q.pop_front()));
         end
      end
      prev_req = irq_req;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int cnt;
      en  = 1'b1;
      ack = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 4'h0);
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req",   32'(irq_req),     32'd0);
      check("rst_vec",   32'(irq_vec),     32'd0);
      check("rst_tmo",   32'(irq_timeout), 32'd0);
      check("rst_busy",  32'(busy),        32'd0);
      check("rst_svc",   32'(svc_count),   32'd0);

      // Basic latency: request visible after three rising edges.
      exp_q.push_back(6'b01_0101);
      set_in(1'b1, 1'b0, 1'b0, 4'b0101);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("lat_early", 32'(irq_req), 32'd0);
      @(negedge clk);
      check("lat_c3",    32'(irq_req), 32'd1);
      check("lat_busy",  32'(busy),    32'd1);
      ack = 1'b1;
      @(negedge clk);
      check("ack_req_drop", 32'(irq_req),   32'd0);
      check("ack_svc1",     32'(svc_count), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("acklow_busy", 32'(busy), 32'd1);
      end
      check("vec_hold", 32'(irq_vec), 32'(6'b01_0101));

      // Same vector again: holdoff plus a fresh stability window.
      exp_q.push_back(6'b01_0101);
      ack = 1'b0;
      wait_req(30, n);
      check("holdoff_gap", 32'(n), 32'd8);
      ack = 1'b1;
      @(negedge clk);
      check("svc2", 32'(svc_count), 32'd2);

      // Bus B wins over C when A is idle.
      set_in(1'b0, 1'b1, 1'b1, 4'b1001);
      exp_q.push_back(6'b10_1001);
      ack = 1'b0;
      wait_req(20, n);
      ack = 1'b1;
      @(negedge clk);
      check("svc3", 32'(svc_count), 32'd3);
      ack = 1'b0;

      // Channel toggling every cycle never settles.
      for (int i = 0; i < 30; i++) begin
         set_in(1'b0, 1'b1, 1'b0, (i % 2 == 1) ? 4'b0001 : 4'b0010);
         @(negedge clk);
      end
      check("toggle_noreq",  32'(irq_req), 32'd0);
      check("toggle_idle",   32'(busy),    32'd0);

      // Timeout with inputs changing while the request is outstanding.
      set_in(1'b0, 1'b0, 1'b1, 4'b0011);
      exp_q.push_back(6'b11_0011);
      wait_req(20, n);
      cnt = 1;
      set_in(1'b1, 1'b0, 1'b0, 4'b1111);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!irq_req) break;
         cnt++;
         check("req_vec_frozen", 32'(irq_vec), 32'(6'b11_0011));
         if (cnt == 3) set_in(1'b0, 1'b0, 1'b0, 4'h0);
      end
      check("tmo_req_len", 32'(cnt),         32'd8);
      check("tmo_pulse",   32'(irq_timeout), 32'd1);
      check("tmo_svc",     32'(svc_count),   32'd3);
      @(negedge clk);
      check("tmo_pulse_end", 32'(irq_timeout), 32'd0);
      repeat (2) @(negedge clk);
      check("tmo_hold_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("tmo_idle_busy", 32'(busy), 32'd0);

      // Ack arrives on the very cycle the timeout would fire.
      set_in(1'b0, 1'b1, 1'b0, 4'b0110);
      exp_q.push_back(6'b10_0110);
      wait_req(20, n);
      repeat (7) @(negedge clk);
      check("tie_req_still", 32'(irq_req), 32'd1);
      ack = 1'b1;
      @(negedge clk);
      check("tie_no_tmo", 32'(irq_timeout), 32'd0);
      check("tie_svc",    32'(svc_count),   32'd4);
      check("tie_req",    32'(irq_req),     32'd0);
      set_in(1'b0, 1'b0, 1'b0, 4'h0);
      ack = 1'b0;
      repeat (8) @(negedge clk);

      // Asynchronous reset in the middle of a request.
      set_in(1'b1, 1'b0, 1'b0, 4'b1010);
      exp_q.push_back(6'b01_1010);
      wait_req(20, n);
      #2 rst_n = 1'b0;
      #1;
      check("arst_req",  32'(irq_req),   32'd0);
      check("arst_busy", 32'(busy),      32'd0);
      check("arst_svc",  32'(svc_count), 32'd0);
      check("arst_vec",  32'(irq_vec),   32'd0);

      // Stale ack while idle blocks any new request.
      ack = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("stale_noreq", 32'(irq_req), 32'd0);
      check("stale_idle",  32'(busy),    32'd0);
      exp_q.push_back(6'b01_1010);
      ack = 1'b0;
      wait_req(10, n);
      check("stale_release", 32'(n), 32'd1);
      ack = 1'b1;
      @(negedge clk);
      check("post_rst_svc", 32'(svc_count), 32'd1);
      ack = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 4'h0);
      repeat (10) @(negedge clk);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/c432_irq_dispatch.md
Name: c432_irq_dispatch

Overview:
- Sequential stage directly downstream of the gf_c432 27-channel priority interrupt encoder.
- Registers and deglitches the encoder's 7 combinational outputs into a bus/channel vector.
- Presents the vector to a CPU-side consumer over a four-phase req/ack handshake, with an acknowledge timeout and a post-service holdoff.
- Counts serviced interrupts.

Parameters:
- STABLE_CYCLES, 2: consecutive identical samples required before a vector is accepted; legal range 1..15.
- TIMEOUT, 255: cycles the block waits for ack before aborting; legal range 1..65535.
- HOLDOFF, 4: idle cycles after each completed or aborted transaction; legal range 0..255.
- CNT_W, 16: width of the service counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  dispatch enable; when low, no new transaction starts.
- G223gat  in  1  encoder bus-A request flag (PA).
- G329gat  in  1  encoder bus-B request flag (PB).
- G370gat  in  1  encoder bus-C request flag (PC).
- G421gat, G430gat, G431gat, G432gat  in  1 each  encoder channel code; chan[3:0] = {G421gat, G430gat, G431gat, G432gat}.
- irq_ack  in  1  consumer acknowledge (four-phase).
- irq_req  out  1  request to consumer.
- irq_vec  out  6  {bus[1:0], chan[3:0]}; held stable while irq_req=1.
- irq_timeout  out  1  one-cycle pulse when a request is aborted.
- busy  out  1  high in any state other than IDLE.
- svc_count  out  CNT_W  number of completed handshakes.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state = IDLE.
  - irq_req, irq_vec, irq_timeout, busy and svc_count all 0.
  - Sample register, stability counter, timeout counter and holdoff counter all 0.
- Input sampling: every cycle the encoder inputs are registered into raw[6:0]. Bus encoding from raw:
  - PA=1 gives bus=01.
  - else PB=1 gives bus=10.
  - else PC=1 gives bus=11.
  - else bus=00, meaning no request.
- Stability filter:
  - cand = {bus, chan}.
  - stab_cnt resets to 1 whenever cand differs from the previous cycle's cand; otherwise it increments, saturating at STABLE_CYCLES.
  - cand is valid when bus != 00 and stab_cnt == STABLE_CYCLES.
- FSM states and transitions:
  - IDLE: if en=1, cand valid and irq_ack=0, then latch irq_vec <= cand, set irq_req=1, clear the timeout counter and go to REQ.
    - If irq_ack=1 in IDLE (stale ack), stay in IDLE.
  - REQ: irq_req=1 and irq_vec frozen, independent of input changes.
    - If irq_ack=1, drop irq_req, increment svc_count and go to ACK_LOW.
    - Else if the timeout counter reaches TIMEOUT-1, drop irq_req, pulse irq_timeout for 1 cycle, leave svc_count unchanged and go to HOLD.
    - Otherwise the timeout counter increments.
  - ACK_LOW: wait for irq_ack=0, then go to HOLD. This state has no timeout.
  - HOLD: count HOLDOFF cycles, then go to IDLE. If HOLDOFF=0, go to IDLE on the next cycle. While in HOLD, stab_cnt is forced to 0, so a fresh STABLE_CYCLES window is required after holdoff.
- Latency: inputs constant from cycle 0 give irq_req=1 at cycle 1+STABLE_CYCLES (1 register stage plus the filter).
- irq_vec holds its last value after the handshake. It updates only when a transaction starts.
- svc_count wraps modulo 2^CNT_W.
- en falling while in REQ/ACK_LOW/HOLD does not abort the transaction; it only prevents the next start.
- Timeout and ack in the same cycle: ack wins, so the transaction completes with no irq_timeout pulse.
- Reset asserted mid-transaction: all outputs return to reset values immediately, asynchronously.
- busy = (state != IDLE).
- All outputs are registered; there is no combinational path from any input to any output.

Decomposition:
- Shared package c432_irq_pkg holds:
  - the state enum IDLE/REQ/ACK_LOW/HOLD;
  - bus code constants BUS_NONE=00, BUS_A=01, BUS_B=10, BUS_C=11;
  - the vector width constant VEC_W=6.
- One sub-module, c432_irq_filter, contains the input register, bus encoder and stability counter. Its output is cand plus cand_valid. The top level holds the FSM, counters and handshake.

Test Plan:
- Reset then PA=1, chan=0101, en=1, ack=0, STABLE_CYCLES=2 -> irq_req rises at cycle 3 with irq_vec=01_0101; ack=1 -> req falls next cycle and svc_count=1.
- PB=1, PC=1, PA=0, chan=1001 -> irq_vec=10_1001. Toggle chan every cycle -> irq_req never asserts.
- ack held 0, TIMEOUT=8 -> irq_req high exactly 8 cycles, then a single irq_timeout pulse, svc_count unchanged, busy low after HOLDOFF.
- Change chan while in REQ -> irq_vec unchanged. After ack, hold ack=1 for 5 cycles -> block stays in ACK_LOW and busy=1.
- Same vector held constant across two transactions, HOLDOFF=4 -> second irq_req no earlier than 4+STABLE_CYCLES cycles after ack falls.
- Assert rst_n=0 mid-REQ -> irq_req, busy and svc_count go to 0 asynchronously. Also start with irq_ack=1 while idle -> no request is issued.
